// File: rtl/enc_binder_pack_seq_pkg.sv
// Shared encoder definitions: hypervector width, per-channel rotation table and binder FSM states.
// Shift amounts are reduced modulo HV_DIM here, so rotators never see out-of-range values.
package enc_binder_pack_seq_pkg;

    localparam int HV_DIM  = 32;
    localparam int SHIFT_W = $clog2(HV_DIM);

    localparam int SHIFTS [16] = '{1, 3, 0, 32, 7, 31, 45, 3, 16, 5, 64, 2, 9, 33, 17, 30};

    typedef logic [HV_DIM-1:0] hv_t;

    typedef enum logic [1:0] {
        IDLE,
        BIND,
        DONE
    } binder_state_t;

    function automatic logic [SHIFT_W-1:0] shift_of(input int idx);
        return SHIFT_W'(SHIFTS[idx] % HV_DIM);
    endfunction

endpackage

// File: rtl/enc_binder_lane.sv
// Combinational barrel rotator: dir=0 rotates left (bind), dir=1 rotates right (unbind).
// Zero latency; no flow control.
module enc_binder_lane
    import enc_binder_pack_seq_pkg::*;
(
    input  hv_t                hv_in,
    input  logic [SHIFT_W-1:0] shamt,
    input  logic               dir,
    output hv_t                hv_out
);

    logic [2*HV_DIM-1:0] dbl;

    // Shifting a doubled copy turns the rotate into a plain shift plus half-select.
    always_comb begin
        dbl    = dir ? ({hv_in, hv_in} >> shamt) : ({hv_in, hv_in} << shamt);
        hv_out = dir ? dbl[HV_DIM-1:0] : dbl[2*HV_DIM-1:HV_DIM];
    end

endmodule

// File: rtl/enc_binder_pack_seq.sv
// Time-multiplexed binder: rotates NUM_CH level HVs through NUM_LANES rotators, NUM_LANES per beat.
// Latency ceil(NUM_CH/NUM_LANES)+1 cycles start-to-done; no backpressure, start ignored while busy.
module enc_binder_pack_seq
    import enc_binder_pack_seq_pkg::*;
#(
    parameter int NUM_CH    = 10,
    parameter int NUM_LANES = 2,
    parameter int BASE_IDX  = 0
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start_encoding,
    input  logic                         unbind,
    input  logic [NUM_CH-1:0][HV_DIM-1:0] level_hv,
    output logic [NUM_CH-1:0][HV_DIM-1:0] shifted_hv,
    output logic                         busy,
    output logic                         done
);

    localparam int NUM_BEATS = (NUM_CH + NUM_LANES - 1) / NUM_LANES;
    localparam int CNT_W     = $clog2(NUM_BEATS + 1);

    if (BASE_IDX + NUM_CH > $size(SHIFTS) || NUM_LANES < 1 || NUM_LANES > NUM_CH) begin : g_bad_params
        $error("enc_binder_pack_seq: SHIFTS table too small or NUM_LANES out of range");
    end

    binder_state_t                 state_q, state_d;
    logic [CNT_W-1:0]              beat_q, beat_d;
    logic                          dir_q, dir_d;
    logic [NUM_CH-1:0][HV_DIM-1:0] shifted_q, shifted_d;

    hv_t                lane_in  [NUM_LANES];
    logic [SHIFT_W-1:0] lane_sh  [NUM_LANES];
    hv_t                lane_out [NUM_LANES];

    // Lane l serves channel beat*NUM_LANES+l; lanes past the last channel see zero and write nothing.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_in[l] = '0;
            lane_sh[l] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (int'(beat_q) * NUM_LANES + l == c) begin
                    lane_in[l] = level_hv[c];
                    lane_sh[l] = shift_of(BASE_IDX + c);
                end
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        enc_binder_lane u_lane (
            .hv_in  (lane_in[l]),
            .shamt  (lane_sh[l]),
            .dir    (dir_q),
            .hv_out (lane_out[l])
        );
    end

    always_comb begin
        shifted_d = shifted_q;
        if (state_q == BIND) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(beat_q) * NUM_LANES + l == c) begin
                        shifted_d[c] = lane_out[l];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (start_encoding) begin
                    dir_d   = unbind;
                    beat_d  = '0;
                    state_d = BIND;
                end
            end
            BIND: begin
                if (beat_q == CNT_W'(NUM_BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            dir_q     <= 1'b0;
            shifted_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            dir_q     <= dir_d;
            shifted_q <= shifted_d;
        end
    end

    assign shifted_hv = shifted_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_enc_binder_pack_seq.sv
// Bench for enc_binder_pack_seq: three lane configurations share one stimulus stream and are
// checked every cycle against a timing/rotation model plus literal expectations.
module tb_enc_binder_pack_seq;
    import enc_binder_pack_seq_pkg::*;

    localparam int NCH = 10;
    localparam int ND  = 3;
    localparam int LANES [ND] = '{2, 4, 10};
    localparam int BASES [ND] = '{0, 0, 4};

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start_encoding = 1'b0;
    logic unbind = 1'b0;
    logic [NCH-1:0][HV_DIM-1:0] level_hv = '0;
    logic [NCH-1:0][HV_DIM-1:0] sh [ND];
    logic bsy [ND];
    logic dn  [ND];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    enc_binder_pack_seq #(.NUM_CH(NCH), .NUM_LANES(2), .BASE_IDX(0)) u_dut_a (
        .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .unbind(unbind),
        .level_hv(level_hv), .shifted_hv(sh[0]), .busy(bsy[0]), .done(dn[0]));

    enc_binder_pack_seq #(.NUM_CH(NCH), .NUM_LANES(4), .BASE_IDX(0)) u_dut_b (
        .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .unbind(unbind),
        .level_hv(level_hv), .shifted_hv(sh[1]), .busy(bsy[1]), .done(dn[1]));

    enc_binder_pack_seq #(.NUM_CH(NCH), .NUM_LANES(10), .BASE_IDX(4)) u_dut_c (
        .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .unbind(unbind),
        .level_hv(level_hv), .shifted_hv(sh[2]), .busy(bsy[2]), .done(dn[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference rotation straight from the index definition.
    function automatic hv_t rot(input hv_t v, input int s, input logic dir);
        hv_t r;
        int  k;
        r = '0;
        k = s % HV_DIM;
        for (int i = 0; i < HV_DIM; i++) begin
            if (!dir) r[(i + k) % HV_DIM] = v[i];
            else      r[i] = v[(i + k) % HV_DIM];
        end
        return r;
    endfunction

    // Model: a run accepted in cycle s is busy in s+1..s+nb+1, done in s+nb+1;
    // channel ch becomes visible from cycle s+2+ch/lanes.
    int  st [ND] = '{-1, -1, -1};
    hv_t nw [ND][NCH];
    hv_t od [ND][NCH];
    int  m_nb, m_rel;
    logic m_eb, m_ed;
    hv_t m_exp;

    initial begin
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < NCH; c++) begin
                od[d][c] = '0;
                nw[d][c] = '0;
            end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            m_nb = (NCH + LANES[d] - 1) / LANES[d];
            if (!nrst) begin
                st[d] = -1;
                for (int c = 0; c < NCH; c++) od[d][c] = '0;
            end else if (st[d] >= 0 && cyc - st[d] > m_nb + 1) begin
                for (int c = 0; c < NCH; c++) od[d][c] = nw[d][c];
                st[d] = -1;
            end
            m_rel = (st[d] >= 0) ? cyc - st[d] : 0;
            m_eb  = (st[d] >= 0) && (m_rel >= 1);
            m_ed  = (st[d] >= 0) && (m_rel == m_nb + 1);
            chk($sformatf("busy_d%0d", d), 64'(bsy[d]), 64'(m_eb));
            chk($sformatf("done_d%0d", d), 64'(dn[d]), 64'(m_ed));
            for (int c = 0; c < NCH; c++) begin
                m_exp = (st[d] >= 0 && (c / LANES[d]) <= m_rel - 2) ? nw[d][c] : od[d][c];
                chk($sformatf("hv_d%0d_ch%0d", d, c), 64'(sh[d][c]), 64'(m_exp));
            end
            if (nrst && st[d] < 0 && start_encoding) begin
                st[d] = cyc;
                for (int c = 0; c < NCH; c++)
                    nw[d][c] = rot(level_hv[c], SHIFTS[BASES[d] + c], unbind);
            end
        end
    end

    function automatic logic [NCH-1:0][HV_DIM-1:0] rand_hv();
        logic [NCH-1:0][HV_DIM-1:0] v;
        for (int c = 0; c < NCH; c++)
            v[c] = HV_DIM'($urandom()) & (($urandom_range(0, 1) != 0) ? HV_DIM'($urandom()) : '1);
        return v;
    endfunction

    task automatic launch(input logic [NCH-1:0][HV_DIM-1:0] hv, input logic dir, output int sc);
        @(posedge clk); #1;
        level_hv = hv;
        unbind = dir;
        start_encoding = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start_encoding = 1'b0;
        unbind = 1'b0;
    endtask

    task automatic wait_done(input int d, input int sc, input int lat, input string nm, output int dc);
        int n;
        n = 0;
        while (!dn[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        dc = cyc;
        if (!dn[d]) begin
            total++;
            bad++;
            $display("FAIL %s: no done within %0d cycles, required latency %0d", nm, n, lat);
        end else begin
            chk(nm, 64'(cyc - sc), 64'(lat));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bsy[0] || bsy[1] || bsy[2]) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (bsy[0] || bsy[1] || bsy[2]) begin
            total++;
            bad++;
            $display("FAIL idle_wait: still busy after %0d cycles, required idle", n);
        end
    endtask

    initial begin
        logic [NCH-1:0][HV_DIM-1:0] hv;
        int sc, sc2, dc, dc2, cnt;

        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        chk("rst_done", 64'(dn[0]), 64'd0);
        chk("rst_hv", 64'(sh[0][5]), 64'd0);

        // Single-bit bind: every channel carries bit 0.
        for (int c = 0; c < NCH; c++) hv[c] = 32'h1;
        launch(hv, 1'b0, sc);
        wait_done(2, sc, 2, "lat_c", dc);
        wait_done(1, sc, 4, "lat_b", dc);
        wait_done(0, sc, 6, "lat_a", dc);
        chk("t2_a_ch1", 64'(sh[0][1]), 64'h8);
        chk("t2_a_ch3", 64'(sh[0][3]), 64'h1);
        chk("t2_a_ch6", 64'(sh[0][6]), 64'h2000);
        chk("t2_c_ch0", 64'(sh[2][0]), 64'h80);
        wait_idle();

        // Wrap-around and its inverse on channel 0 (shift 1).
        hv = rand_hv();
        hv[0] = 32'h8000_0000;
        launch(hv, 1'b0, sc);
        wait_idle();
        chk("t3_wrap_a", 64'(sh[0][0]), 64'h1);
        chk("t3_wrap_b", 64'(sh[1][0]), 64'h1);
        hv[0] = 32'h1;
        launch(hv, 1'b1, sc);
        wait_idle();
        chk("t3_unwrap", 64'(sh[0][0]), 64'h8000_0000);

        // Start with unbind=1 during beat 1 must be ignored.
        hv = rand_hv();
        hv[1] = 32'h1;
        launch(hv, 1'b0, sc);
        cnt = 0;
        @(posedge clk); #1;
        start_encoding = 1'b1;
        unbind = 1'b1;
        if (dn[0]) cnt++;
        @(posedge clk); #1;
        start_encoding = 1'b0;
        unbind = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (dn[0]) cnt++;
            @(posedge clk); #1;
        end
        chk("t5_done_cnt", 64'(cnt), 64'd1);
        chk("t5_left", 64'(sh[0][1]), 64'h8);
        wait_idle();

        // Reset during beat 2: outputs clear at once, no done.
        launch(rand_hv(), 1'b0, sc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("t1_busy", 64'(bsy[0]), 64'd0);
        chk("t1_hv", 64'(sh[0][0]), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) nrst = 1'b1;
            if (dn[0]) cnt++;
            @(posedge clk); #1;
        end
        chk("t1_no_done", 64'(cnt), 64'd0);
        launch(rand_hv(), 1'b0, sc);
        wait_done(0, sc, 6, "t1_rerun", dc);
        wait_idle();

        // Back-to-back: start the cycle after done.
        launch(rand_hv(), 1'b0, sc);
        wait_done(0, sc, 6, "t6_first", dc);
        launch(rand_hv(), 1'b1, sc2);
        wait_done(0, sc2, 6, "t6_second", dc2);
        chk("t6_spacing", 64'(dc2 - dc), 64'd7);
        wait_idle();

        // Random runs with stray start pulses while busy.
        for (int r = 0; r < 10; r++) begin
            launch(rand_hv(), 1'($urandom_range(0, 1)), sc);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            start_encoding = 1'b1;
            unbind = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            start_encoding = 1'b0;
            unbind = 1'b0;
            wait_idle();
            for (int c = 0; c < NCH; c++)
                chk("t4_pop_b", 64'($countones(sh[1][c])), 64'($countones(level_hv[c])));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
